// File: rtl/temp_threshold_detector.sv
// temp_threshold_detector: windowed sample averaging with hysteresis and debounced cold/hot flags
module temp_threshold_detector #(
    parameter int TEMP_W   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 2,
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample_temp,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              avg_valid,
    output logic [TEMP_W-1:0] avg_temp,
    output logic              too_cold,
    output logic              too_hot
);
    localparam int ACC_W = TEMP_W + AVG_LOG2;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {NORMAL, COLD, HOT} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [AVG_LOG2-1:0] scnt_q, scnt_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d, inc;
    logic                dir_hot_q, dir_hot_d;
    logic                avg_valid_q, avg_valid_d;
    logic [TEMP_W-1:0]   avg_temp_q, avg_temp_d, avg;
    logic                too_cold_q, too_cold_d, too_hot_q, too_hot_d;
    logic [TEMP_W:0]     avg_x, sp_x, hyst_x;
    logic                win, qual, cold_on, cold_off, hot_on, hot_off;

    always_comb begin
        sum         = acc_q + ACC_W'(sample_temp);
        win         = sample_valid && (scnt_q == '1);
        avg         = TEMP_W'(sum >> AVG_LOG2);
        avg_x       = {1'b0, avg};
        sp_x        = {1'b0, setpoint};
        hyst_x      = (TEMP_W+1)'(HYST);
        cold_on     = avg_x + hyst_x < sp_x;
        cold_off    = avg_x >= sp_x;
        hot_on      = avg_x > sp_x + hyst_x;
        hot_off     = avg_x <= sp_x;
        acc_d       = sample_valid ? (win ? '0 : sum) : acc_q;
        scnt_d      = sample_valid ? scnt_q + 1'b1 : scnt_q;
        avg_valid_d = win;
        avg_temp_d  = win ? avg : avg_temp_q;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        dir_hot_d   = dir_hot_q;
        qual        = 1'b0;
        inc         = '0;
        if (win) begin
            qual      = state_q == NORMAL ? (cold_on || hot_on) : state_q == COLD ? cold_off : hot_off;
            inc       = (state_q == NORMAL && hot_on != dir_hot_q) ? CNT_W'(1) : dcnt_q + 1'b1;
            dir_hot_d = hot_on;
            if (!qual) begin
                dcnt_d = '0;
            end else if (inc == CNT_W'(DEBOUNCE)) begin
                dcnt_d  = '0;
                state_d = state_q != NORMAL ? NORMAL : (hot_on ? HOT : COLD);
            end else begin
                dcnt_d = inc;
            end
        end
        too_cold_d = state_d == COLD;
        too_hot_d  = state_d == HOT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= NORMAL;
            acc_q       <= '0;
            scnt_q      <= '0;
            dcnt_q      <= '0;
            dir_hot_q   <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_temp_q  <= '0;
            too_cold_q  <= 1'b0;
            too_hot_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            scnt_q      <= scnt_d;
            dcnt_q      <= dcnt_d;
            dir_hot_q   <= dir_hot_d;
            avg_valid_q <= avg_valid_d;
            avg_temp_q  <= avg_temp_d;
            too_cold_q  <= too_cold_d;
            too_hot_q   <= too_hot_d;
        end
    end

    assign avg_valid = avg_valid_q;
    assign avg_temp  = avg_temp_q;
    assign too_cold  = too_cold_q;
    assign too_hot   = too_hot_q;
endmodule

// File: tb/tb_temp_threshold_detector.sv
// tb_temp_threshold_detector: directed window vectors and corner sequences for temp_threshold_detector
module tb_temp_threshold_detector;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample_temp;
    logic [7:0] setpoint;
    logic       avg_valid;
    logic [7:0] avg_temp;
    logic       too_cold;
    logic       too_hot;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int avg;
        bit cold;
        bit hot;
    } vec_t;

    vec_t tbl[$];

    temp_threshold_detector #(
        .TEMP_W(8), .AVG_LOG2(2), .HYST(2), .DEBOUNCE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_temp(sample_temp),
        .setpoint(setpoint), .avg_valid(avg_valid), .avg_temp(avg_temp),
        .too_cold(too_cold), .too_hot(too_hot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic smp(input int v);
        sample_valid = 1'b1;
        sample_temp  = 8'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic window(input int v);
        for (int i = 0; i < 4; i++) smp(v);
    endtask

    task automatic chk_win(input string name, input int a, input int c, input int h);
        chk({name, "_valid"}, int'(avg_valid), 1);
        chk({name, "_avg"}, int'(avg_temp), a);
        chk({name, "_cold"}, int'(too_cold), c);
        chk({name, "_hot"}, int'(too_hot), h);
        chk({name, "_excl"}, int'(too_cold & too_hot), 0);
    endtask

    initial begin
        tbl.push_back('{17, 0, 0}); tbl.push_back('{17, 0, 0}); tbl.push_back('{18, 0, 0});
        tbl.push_back('{17, 0, 0}); tbl.push_back('{17, 0, 0}); tbl.push_back('{17, 1, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{19, 1, 0});
        tbl.push_back('{20, 1, 0}); tbl.push_back('{20, 1, 0}); tbl.push_back('{20, 0, 0});
        for (int i = 0; i < 3; i++) tbl.push_back('{22, 0, 0});
        tbl.push_back('{23, 0, 0}); tbl.push_back('{23, 0, 0}); tbl.push_back('{23, 0, 1});
        tbl.push_back('{20, 0, 1}); tbl.push_back('{20, 0, 1}); tbl.push_back('{20, 0, 0});
        tbl.push_back('{23, 0, 0}); tbl.push_back('{23, 0, 0}); tbl.push_back('{17, 0, 0});
        tbl.push_back('{17, 0, 0}); tbl.push_back('{23, 0, 0}); tbl.push_back('{17, 0, 0});
        tbl.push_back('{17, 0, 0}); tbl.push_back('{17, 1, 0});
        tbl.push_back('{20, 1, 0}); tbl.push_back('{20, 1, 0}); tbl.push_back('{20, 0, 0});

        rst_n = 1'b0;
        sample_valid = 1'b1;
        sample_temp = 8'd99;
        setpoint = 8'd20;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(avg_valid), 0);
        chk("rst_avg", int'(avg_temp), 0);
        chk("rst_cold", int'(too_cold), 0);
        chk("rst_hot", int'(too_hot), 0);
        rst_n = 1'b1;
        sample_valid = 1'b0;

        smp(20); smp(21); smp(22);
        chk("avg_early", int'(avg_valid), 0);
        smp(23);
        chk_win("avg_first", 21, 0, 0);
        @(posedge clk);
        #1;
        chk("avg_pulse_drop", int'(avg_valid), 0);
        chk("avg_hold", int'(avg_temp), 21);

        foreach (tbl[i]) begin
            window(tbl[i].avg);
            chk_win($sformatf("tbl%0d", i), tbl[i].avg, int'(tbl[i].cold), int'(tbl[i].hot));
        end

        for (int i = 0; i < 3; i++) window(17);
        chk("pre_rst_cold", int'(too_cold), 1);
        smp(255);
        repeat (3) @(posedge clk);
        #1;
        smp(255);
        chk("sparse_partial", int'(avg_valid), 0);
        rst_n = 1'b0;
        sample_valid = 1'b1;
        sample_temp = 8'd99;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample_valid = 1'b0;
        chk("mid_rst_valid", int'(avg_valid), 0);
        chk("mid_rst_avg", int'(avg_temp), 0);
        chk("mid_rst_cold", int'(too_cold), 0);
        chk("mid_rst_hot", int'(too_hot), 0);
        for (int i = 0; i < 4; i++) begin
            smp(10);
            if (i < 3) begin
                chk($sformatf("sparse_idle%0d", i), int'(avg_valid), 0);
                repeat (2) @(posedge clk);
                #1;
            end
        end
        chk_win("sparse10", 10, 0, 0);
        window(255);
        chk_win("max255", 255, 0, 0);

        setpoint = 8'd1;
        for (int i = 0; i < 3; i++) begin
            window(0);
            chk_win($sformatf("uflow%0d", i), 0, 0, 0);
        end
        setpoint = 8'd255;
        for (int i = 0; i < 3; i++) begin
            window(255);
            chk_win($sformatf("oflow%0d", i), 255, 0, 0);
        end
        setpoint = 8'd1;
        for (int i = 0; i < 3; i++) begin
            window(4);
            chk_win($sformatf("lowsp_hot%0d", i), 4, 0, i == 2 ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
